// File: rtl/soc_selftest_pkg.sv
// Shared types and constants for the factorial self-test sequencer.
package soc_selftest_pkg;

    // Sequencer states; 3-bit encoding leaves two spare codes that fall back to idle.
    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StSocRst,
        StRun,
        StCheck,
        StDone
    } state_t;

    // Default width of the error/timeout counters; they stop at all-ones of this width.
    localparam int unsigned CntWDefault = 16;

    // PC of the final instruction of the factorial program in the SoC memory map.
    localparam logic [31:0] DonePcDefault = 32'h34;

endpackage

// File: rtl/soc_selftest_sequencer_fact_ref.sv
// Iterative factorial engine: one multiply per cycle, result truncated to DATA_W bits.
module fact_ref #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] n,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] result
);

    logic              running_q;
    logic [DATA_W-1:0] acc_q;
    // One bit wider than n so k can step past the largest representable n.
    logic [DATA_W:0]   k_q;
    logic              k_past_n;

    assign k_past_n = k_q > {1'b0, n};
    assign busy     = running_q && !k_past_n;
    assign valid    = running_q && k_past_n;
    assign result   = acc_q;

    // Accumulator and multiplier index; start reloads acc=1, k=2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            acc_q     <= '0;
            k_q       <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            acc_q     <= DATA_W'(1);
            k_q       <= (DATA_W + 1)'(2);
        end else if (busy) begin
            acc_q <= acc_q * k_q[DATA_W-1:0];
            k_q   <= k_q + (DATA_W + 1)'(1);
        end else if (valid) begin
            running_q <= 1'b0;
        end
    end

endmodule

// File: rtl/soc_selftest_sequencer.sv
// Runs the SoC factorial program for every n in [N_FIRST..N_LAST] and scores the results.
module soc_selftest_sequencer
    import soc_selftest_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned N_FIRST     = 0,
    parameter int unsigned N_LAST      = 12,
    parameter logic [31:0] DONE_PC     = DonePcDefault,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned RST_CYC     = 2,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       pc_current,
    input  logic [DATA_W-1:0] gp_result,
    output logic [DATA_W-1:0] gp_arg,
    output logic              soc_rst,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] cur_n,
    output logic [DATA_W-1:0] exp_value,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  timeout_count,
    output logic              fail_valid,
    output logic [DATA_W-1:0] fail_n
);

    if (N_LAST < N_FIRST) begin : g_bad_range
        $error("soc_selftest_sequencer: N_LAST must be >= N_FIRST");
    end

    localparam logic [DATA_W-1:0] NFirstVal   = DATA_W'(N_FIRST);
    localparam logic [DATA_W-1:0] NLastVal    = DATA_W'(N_LAST);
    localparam logic [31:0]       RstLast     = 32'(RST_CYC - 1);
    localparam logic [31:0]       TimeoutLast = 32'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CntMax      = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cur_n_q, cur_n_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  to_q, to_d;
    logic              fv_q, fv_d;
    logic [DATA_W-1:0] fn_q, fn_d;
    logic [31:0]       cyc_q, cyc_d;
    logic              pc_hit_q, pc_hit_d;

    logic              pc_hit, run_done;
    logic              enter_calc, fail, timeout, advance;
    logic              fact_start, fact_busy, fact_valid;
    logic [DATA_W-1:0] fact_result;

    assign pc_hit     = pc_current == DONE_PC;
    // Only a rising edge counts, so a PC parked at DONE_PC across the SoC reset is ignored.
    assign run_done   = pc_hit && !pc_hit_q;
    assign fact_start = enter_calc && !fact_busy;

    fact_ref #(
        .DATA_W(DATA_W)
    ) u_fact (
        .clk   (clk),
        .rst   (rst),
        .start (fact_start),
        .n     (cur_n_q),
        .busy  (fact_busy),
        .valid (fact_valid),
        .result(fact_result)
    );

    // Next-state, scoring and advance logic.
    always_comb begin
        state_d    = state_q;
        cur_n_d    = cur_n_q;
        exp_d      = exp_q;
        err_d      = err_q;
        to_d       = to_q;
        fv_d       = fv_q;
        fn_d       = fn_q;
        cyc_d      = '0;
        pc_hit_d   = pc_hit;
        enter_calc = 1'b0;
        fail       = 1'b0;
        timeout    = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StCalc;
                    cur_n_d    = NFirstVal;
                    exp_d      = '0;
                    err_d      = '0;
                    to_d       = '0;
                    fv_d       = 1'b0;
                    fn_d       = '0;
                    enter_calc = 1'b1;
                end
            end
            StCalc: begin
                if (fact_valid) begin
                    exp_d   = fact_result;
                    state_d = StSocRst;
                end
            end
            StSocRst: begin
                pc_hit_d = 1'b1;
                if (cyc_q == RstLast) state_d = StRun;
                else                  cyc_d   = cyc_q + 32'd1;
            end
            StRun: begin
                if (run_done) begin
                    state_d = StCheck;
                end else if (cyc_q == TimeoutLast) begin
                    timeout = 1'b1;
                    fail    = 1'b1;
                    advance = 1'b1;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            StCheck: begin
                fail    = gp_result != exp_q;
                advance = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (timeout && to_q != CntMax) to_d = to_q + CNT_W'(1);
        if (fail) begin
            if (err_q != CntMax) err_d = err_q + CNT_W'(1);
            if (!fv_q) begin
                fv_d = 1'b1;
                fn_d = cur_n_q;
            end
        end
        if (advance) begin
            if (cur_n_q == NLastVal) begin
                state_d = StDone;
            end else begin
                cur_n_d    = cur_n_q + DATA_W'(1);
                state_d    = StCalc;
                enter_calc = 1'b1;
            end
        end
    end

    // State and result registers; reset returns every output to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cur_n_q  <= '0;
            exp_q    <= '0;
            err_q    <= '0;
            to_q     <= '0;
            fv_q     <= 1'b0;
            fn_q     <= '0;
            cyc_q    <= '0;
            pc_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_n_q  <= cur_n_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            to_q     <= to_d;
            fv_q     <= fv_d;
            fn_q     <= fn_d;
            cyc_q    <= cyc_d;
            pc_hit_q <= pc_hit_d;
        end
    end

    assign soc_rst       = state_q == StSocRst;
    assign busy          = state_q != StIdle && state_q != StDone;
    assign done          = state_q == StDone;
    assign pass          = done && err_q == '0;
    assign gp_arg        = cur_n_q;
    assign cur_n         = cur_n_q;
    assign exp_value     = exp_q;
    assign err_count     = err_q;
    assign timeout_count = to_q;
    assign fail_valid    = fv_q;
    assign fail_n        = fn_q;

endmodule

// File: tb/tb_soc_selftest_sequencer.sv
// Directed bench: table of SoC-model scenarios plus hand-written timing/reset sequences.
module tb_soc_selftest_sequencer;

    localparam logic [31:0] DonePc = 32'h34;
    localparam logic [31:0] IdlePc = 32'h100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reference factorials 0!..12! (entries 13..15 unused).
    logic [31:0] fact_tab [0:15] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720,
                                     32'd5040, 32'd40320, 32'd362880, 32'd3628800,
                                     32'd39916800, 32'd479001600, 32'd0, 32'd0, 32'd0};

    // Instance A: 32-bit, n = 0..12, short timeout.
    logic        rst_a = 1'b1, start_a = 1'b0;
    logic [31:0] pc_a = IdlePc, res_a = '0;
    logic [31:0] gp_arg_a, cur_n_a, exp_a, fn_a;
    logic        soc_rst_a, busy_a, done_a, pass_a, fv_a;
    logic [15:0] err_a, to_a;

    soc_selftest_sequencer #(
        .DATA_W(32), .N_FIRST(0), .N_LAST(12), .DONE_PC(32'h34),
        .TIMEOUT_CYC(100), .RST_CYC(2), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .pc_current(pc_a), .gp_result(res_a),
        .gp_arg(gp_arg_a), .soc_rst(soc_rst_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .cur_n(cur_n_a), .exp_value(exp_a), .err_count(err_a), .timeout_count(to_a),
        .fail_valid(fv_a), .fail_n(fn_a)
    );

    // Instance B: 16-bit, single argument n = 9.
    logic        rst_b = 1'b1, start_b = 1'b0;
    logic [31:0] pc_b = IdlePc;
    logic [15:0] res_b = '0;
    logic [15:0] gp_arg_b, cur_n_b, exp_b, fn_b, err_b, to_b;
    logic        soc_rst_b, busy_b, done_b, pass_b, fv_b;

    soc_selftest_sequencer #(
        .DATA_W(16), .N_FIRST(9), .N_LAST(9), .DONE_PC(32'h34),
        .TIMEOUT_CYC(4096), .RST_CYC(2), .CNT_W(16)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .pc_current(pc_b), .gp_result(res_b),
        .gp_arg(gp_arg_b), .soc_rst(soc_rst_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .cur_n(cur_n_b), .exp_value(exp_b), .err_count(err_b), .timeout_count(to_b),
        .fail_valid(fv_b), .fail_n(fn_b)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // SoC model A knobs (-1 = off).
    int bad_n = -1;    // returns 121 instead of n!
    int hang_n = -1;   // never reaches DONE_PC
    int hold_n = -1;   // PC parked at DONE_PC through reset and 4 RUN cycles, then a fresh pulse
    int stuck_n = -1;  // PC parked at DONE_PC forever
    int m_cnt = 1000;
    int mb_cnt = 1000;

    // SoC model A: completion pulse 20 cycles after soc_rst falls.
    always @(negedge clk) begin
        if (soc_rst_a) m_cnt = 0;
        else if (m_cnt < 10000) m_cnt++;
        if (int'(gp_arg_a) == stuck_n) pc_a = DonePc;
        else if (soc_rst_a) pc_a = (int'(gp_arg_a) == hold_n) ? DonePc : IdlePc;
        else if (int'(gp_arg_a) == hang_n) pc_a = IdlePc;
        else if (m_cnt == 20 || (int'(gp_arg_a) == hold_n && m_cnt < 5)) pc_a = DonePc;
        else pc_a = IdlePc;
        res_a = (int'(gp_arg_a) == bad_n) ? 32'd121 : fact_tab[gp_arg_a[3:0]];
    end

    // SoC model B: always correct, 9! mod 2^16.
    always @(negedge clk) begin
        if (soc_rst_b) mb_cnt = 0;
        else if (mb_cnt < 10000) mb_cnt++;
        pc_b  = (!soc_rst_b && mb_cnt == 20) ? DonePc : IdlePc;
        res_b = 16'd35200;
    end

    // On each SoC reset of A: expected value already loaded, reset held exactly 2 cycles.
    logic prev_sr = 1'b0;
    int   sr_len = 0;
    always @(negedge clk) begin
        if (soc_rst_a) begin
            if (!prev_sr) begin
                check("socrst_exp_value", 64'(exp_a), 64'(fact_tab[cur_n_a[3:0]]));
                sr_len = 0;
            end
            sr_len++;
        end else if (prev_sr) begin
            check("socrst_len", 64'(sr_len), 64'd2);
        end
        prev_sr = soc_rst_a;
    end

    task automatic check_zero_a(input string p);
        check({p, "_soc_rst"}, 64'(soc_rst_a), 64'd0);
        check({p, "_busy"}, 64'(busy_a), 64'd0);
        check({p, "_done"}, 64'(done_a), 64'd0);
        check({p, "_pass"}, 64'(pass_a), 64'd0);
        check({p, "_gp_arg"}, 64'(gp_arg_a), 64'd0);
        check({p, "_cur_n"}, 64'(cur_n_a), 64'd0);
        check({p, "_exp_value"}, 64'(exp_a), 64'd0);
        check({p, "_err"}, 64'(err_a), 64'd0);
        check({p, "_timeouts"}, 64'(to_a), 64'd0);
        check({p, "_fail_valid"}, 64'(fv_a), 64'd0);
        check({p, "_fail_n"}, 64'(fn_a), 64'd0);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int c = 0;
        while (!done_a && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check(name, 64'(done_a), 64'd1);
    endtask

    typedef struct {
        int bad_n;
        int hang_n;
        int hold_n;
        int stuck_n;
        bit do_rst;
        int exp_err;
        int exp_to;
        bit exp_fv;
        int exp_fn;
        bit exp_pass;
    } scen_t;

    scen_t tab [8];

    initial begin
        int c;
        int run_cyc;

        //          bad hang hold stuck rst  err to fv fn  pass
        tab[0] = '{-1, -1, -1, -1, 1'b1, 0, 0, 1'b0, 0,  1'b1};
        tab[1] = '{ 5, -1, -1, -1, 1'b1, 1, 0, 1'b1, 5,  1'b0};
        tab[2] = '{-1,  3, -1, -1, 1'b1, 1, 1, 1'b1, 3,  1'b0};
        tab[3] = '{-1, -1,  6, -1, 1'b0, 0, 0, 1'b0, 0,  1'b1};
        tab[4] = '{-1, -1, -1,  8, 1'b1, 1, 1, 1'b1, 8,  1'b0};
        tab[5] = '{ 5,  3, -1, -1, 1'b0, 2, 1, 1'b1, 3,  1'b0};
        tab[6] = '{-1, 12, -1, -1, 1'b1, 1, 1, 1'b1, 12, 1'b0};
        tab[7] = '{-1, -1,  0, -1, 1'b0, 0, 0, 1'b0, 0,  1'b1};

        repeat (3) @(negedge clk);
        check_zero_a("reset");
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy_a), 64'd0);
        check("idle_done", 64'(done_a), 64'd0);

        for (int i = 0; i < 8; i++) begin
            bad_n   = tab[i].bad_n;
            hang_n  = tab[i].hang_n;
            hold_n  = tab[i].hold_n;
            stuck_n = tab[i].stuck_n;
            if (tab[i].do_rst) begin
                @(negedge clk);
                rst_a = 1'b1;
                @(negedge clk);
                rst_a = 1'b0;
            end
            pulse_start_a();
            check($sformatf("scen%0d_busy_after_start", i), 64'(busy_a), 64'd1);
            wait_done_a($sformatf("scen%0d_done", i));
            check($sformatf("scen%0d_busy", i), 64'(busy_a), 64'd0);
            check($sformatf("scen%0d_pass", i), 64'(pass_a), 64'(tab[i].exp_pass));
            check($sformatf("scen%0d_err", i), 64'(err_a), 64'(tab[i].exp_err));
            check($sformatf("scen%0d_timeouts", i), 64'(to_a), 64'(tab[i].exp_to));
            check($sformatf("scen%0d_fail_valid", i), 64'(fv_a), 64'(tab[i].exp_fv));
            check($sformatf("scen%0d_fail_n", i), 64'(fn_a), 64'(tab[i].exp_fn));
            check($sformatf("scen%0d_cur_n", i), 64'(cur_n_a), 64'd12);
            check($sformatf("scen%0d_exp_value", i), 64'(exp_a), 64'd479001600);
        end

        // Timeout at n=3 lands exactly 100 RUN cycles after soc_rst falls.
        bad_n = -1; hang_n = 3; hold_n = -1; stuck_n = -1;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        pulse_start_a();
        c = 0;
        while (!(soc_rst_a && cur_n_a == 32'd3) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        while (soc_rst_a && c < 10) begin
            @(negedge clk);
            c++;
        end
        run_cyc = 0;
        while (to_a == 16'd0 && run_cyc < 300) begin
            @(negedge clk);
            run_cyc++;
        end
        check("to_run_cycles", 64'(run_cyc), 64'd100);
        check("to_timeouts", 64'(to_a), 64'd1);
        check("to_err", 64'(err_a), 64'd1);
        check("to_fail_valid", 64'(fv_a), 64'd1);
        check("to_fail_n", 64'(fn_a), 64'd3);
        check("to_cur_n_next", 64'(cur_n_a), 64'd4);

        // start while busy is ignored; rst mid-RUN at n=7 clears everything at once.
        hang_n = -1;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        pulse_start_a();
        c = 0;
        while (cur_n_a != 32'd5 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_start_cur_n", 64'(cur_n_a), 64'd5);
        check("busy_start_busy", 64'(busy_a), 64'd1);
        c = 0;
        while (!(soc_rst_a && cur_n_a == 32'd7) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        while (soc_rst_a && c < 10) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        check("midrun_busy_pre", 64'(busy_a), 64'd1);
        check("midrun_cur_n_pre", 64'(cur_n_a), 64'd7);
        #2 rst_a = 1'b1;
        #1 check_zero_a("midrun_rst");
        @(negedge clk);
        rst_a = 1'b0;
        pulse_start_a();
        check("restart_cur_n", 64'(cur_n_a), 64'd0);
        check("restart_busy", 64'(busy_a), 64'd1);
        check("restart_err", 64'(err_a), 64'd0);
        wait_done_a("restart_done");
        check("restart_pass", 64'(pass_a), 64'd1);
        check("restart_err_end", 64'(err_a), 64'd0);

        // 16-bit instance: 9! mod 65536, CALC lasts 9 cycles.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        c = 0;
        while (!soc_rst_b && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("b_calc_cycles", 64'(c), 64'd9);
        check("b_exp_value", 64'(exp_b), 64'd35200);
        check("b_gp_arg", 64'(gp_arg_b), 64'd9);
        c = 0;
        while (!done_b && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("b_done", 64'(done_b), 64'd1);
        check("b_pass", 64'(pass_b), 64'd1);
        check("b_err", 64'(err_b), 64'd0);
        check("b_timeouts", 64'(to_b), 64'd0);
        check("b_fail_valid", 64'(fv_b), 64'd0);
        check("b_cur_n", 64'(cur_n_b), 64'd9);
        check("b_busy", 64'(busy_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
